// File: rtl/chs_pkg.sv
// chs_pkg: shared constants for the cooler/heater power ramp.
//   - FSM state encoding (IDLE, RAMP, DRAIN, HOLD)
//   - applied-mode encoding (heat = 1, cool = 0)
package chs_pkg;

    localparam int unsigned CHS_ST_W = 2;

    localparam logic [CHS_ST_W-1:0] CHS_ST_IDLE  = 2'd0;
    localparam logic [CHS_ST_W-1:0] CHS_ST_RAMP  = 2'd1;
    localparam logic [CHS_ST_W-1:0] CHS_ST_DRAIN = 2'd2;
    localparam logic [CHS_ST_W-1:0] CHS_ST_HOLD  = 2'd3;

    localparam logic CHS_MODE_HEAT = 1'b1;
    localparam logic CHS_MODE_COOL = 1'b0;

endpackage

// File: rtl/chs_power_ramp_popcount.sv
// chs_popcount: combinational population count of the configuration word.
//   conf    [CONF_W-1:0] : configuration word
//   count_c [PWR_W-1:0]  : number of set bits (full width, never truncated)
module chs_popcount
    import chs_pkg::*;
#(
    parameter int unsigned CONF_W = 8,
    parameter int unsigned PWR_W  = $clog2(CONF_W + 1)
) (
    input  logic [CONF_W-1:0] conf,
    output logic [PWR_W-1:0]  count_c
);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < CONF_W; i++) begin
            count_c = count_c + PWR_W'(conf[i]);
        end
    end

endmodule

// File: rtl/chs_power_ramp.sv
// chs_power_ramp: applies a cooler/heater power setting derived from a
// configuration word (power = popcount, mode = power LSB).
//   clk, rst          : clock, asynchronous active-high reset
//   chs_conf_valid/chs_conf/chs_conf_ready : configuration handshake
//   chs_power         : applied power, 0..CONF_W
//   chs_mode          : applied mode, heat = 1, cool = 0
//   chs_busy          : high while ramping or draining
//   chs_done          : one-cycle pulse when the applied state reaches target
// Build option CHS_SOFT_START_EN: when defined, power ramps one step every
// RAMP_DIV cycles and drains to zero before a mode change; when undefined,
// the target is applied in a single step one edge after acceptance.
module chs_power_ramp
    import chs_pkg::*;
#(
    parameter int unsigned CONF_W   = 8,
    parameter int unsigned RAMP_DIV = 4,
    localparam int unsigned PWR_W   = $clog2(CONF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chs_conf_valid,
    input  logic [CONF_W-1:0] chs_conf,
    output logic              chs_conf_ready,
    output logic [PWR_W-1:0]  chs_power,
    output logic              chs_mode,
    output logic              chs_busy,
    output logic              chs_done
);

    localparam int unsigned PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [CHS_ST_W-1:0] state, state_n;
    logic [PRESC_W-1:0]  presc, presc_n;
    logic [PWR_W-1:0]    tgt_power, tgt_power_n;
    logic                tgt_mode, tgt_mode_n;
    logic [PWR_W-1:0]    power_n;
    logic                mode_n;
    logic                done_n;
    logic                pend, pend_n;
    logic                tick;
    logic                conf_mode;
    logic [PWR_W-1:0]    conf_power_c;

    chs_popcount #(
        .CONF_W (CONF_W),
        .PWR_W  (PWR_W)
    ) u_popcount (
        .conf    (chs_conf),
        .count_c (conf_power_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= CHS_ST_IDLE;
            presc          <= '0;
            tgt_power      <= '0;
            tgt_mode       <= CHS_MODE_COOL;
            pend           <= 1'b0;
            chs_power      <= '0;
            chs_mode       <= CHS_MODE_COOL;
            chs_done       <= 1'b0;
            chs_busy       <= 1'b0;
            chs_conf_ready <= 1'b1;
        end else begin
            state          <= state_n;
            presc          <= presc_n;
            tgt_power      <= tgt_power_n;
            tgt_mode       <= tgt_mode_n;
            pend           <= pend_n;
            chs_power      <= power_n;
            chs_mode       <= mode_n;
            chs_done       <= done_n;
            chs_busy       <= (state_n == CHS_ST_RAMP) || (state_n == CHS_ST_DRAIN);
            chs_conf_ready <= (state_n == CHS_ST_IDLE) || (state_n == CHS_ST_HOLD);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        presc_n     = presc;
        tgt_power_n = tgt_power;
        tgt_mode_n  = tgt_mode;
        power_n     = chs_power;
        mode_n      = chs_mode;
        pend_n      = 1'b0;
        done_n      = 1'b0;
        tick        = (presc == PRESC_W'(RAMP_DIV - 1));
        conf_mode   = conf_power_c[0] ? CHS_MODE_HEAT : CHS_MODE_COOL;

        // Single-step apply, one edge after acceptance (already-equal or no soft start)
        if (pend) begin
            power_n = tgt_power;
            mode_n  = tgt_mode;
            done_n  = 1'b1;
        end

        case (state)
            CHS_ST_IDLE, CHS_ST_HOLD: begin
                if (chs_conf_valid && chs_conf_ready) begin
                    tgt_power_n = conf_power_c;
                    tgt_mode_n  = conf_mode;
                    presc_n     = '0;
`ifdef CHS_SOFT_START_EN
                    if ((conf_mode != chs_mode) && (chs_power != '0)) begin
                        state_n = CHS_ST_DRAIN;
                    end else if (conf_power_c == chs_power) begin
                        state_n = CHS_ST_HOLD;
                        mode_n  = conf_mode;
                        pend_n  = 1'b1;
                    end else begin
                        // mode may only differ here when power is already 0
                        state_n = CHS_ST_RAMP;
                        mode_n  = conf_mode;
                    end
`else
                    state_n = CHS_ST_HOLD;
                    pend_n  = 1'b1;
`endif
                end
            end

            CHS_ST_RAMP: begin
                presc_n = tick ? '0 : presc + PRESC_W'(1);
                if (tick) begin
                    if (chs_power < tgt_power) begin
                        power_n = chs_power + PWR_W'(1);
                    end else if (chs_power > tgt_power) begin
                        power_n = chs_power - PWR_W'(1);
                    end
                    if (power_n == tgt_power) begin
                        state_n = CHS_ST_HOLD;
                        done_n  = 1'b1;
                    end
                end
            end

            CHS_ST_DRAIN: begin
                presc_n = tick ? '0 : presc + PRESC_W'(1);
                if (tick && (chs_power != '0)) begin
                    power_n = chs_power - PWR_W'(1);
                    // mode flips only on the edge that lands on zero power
                    if (power_n == '0) begin
                        mode_n = tgt_mode;
                        if (tgt_power == '0) begin
                            state_n = CHS_ST_HOLD;
                            done_n  = 1'b1;
                        end else begin
                            state_n = CHS_ST_RAMP;
                        end
                    end
                end
            end

            default: state_n = CHS_ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_chs_power_ramp.sv
// tb_chs_power_ramp: scoreboard bench for chs_power_ramp (CONF_W=8, RAMP_DIV=4).
// The driver predicts each accepted word's full response (trajectory and
// done latency) from plain arithmetic and queues it; the monitor compares
// every cycle and retires an entry on its done pulse.
module tb_chs_power_ramp;

    localparam int unsigned CONF_W   = 8;
    localparam int unsigned RAMP_DIV = 4;
    localparam int unsigned PWR_W    = $clog2(CONF_W + 1);

    typedef struct {
        int unsigned acc;   // cycle index of the accepting edge
        int unsigned p0;    // power before acceptance
        bit          m0;    // mode before acceptance
        int unsigned t;     // target power
        bit          tm;    // target mode
        int unsigned lat;   // edges from acceptance to done
        bit          moves; // goes through RAMP/DRAIN (busy while moving)
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              chs_conf_valid;
    logic [CONF_W-1:0] chs_conf;
    logic              chs_conf_ready;
    logic [PWR_W-1:0]  chs_power;
    logic              chs_mode;
    logic              chs_busy;
    logic              chs_done;

    txn_t        sb[$];
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cur_p    = 0;
    bit          cur_m    = 1'b0;
    int unsigned last_p   = 0;
    bit          last_m   = 1'b0;
    int unsigned pend_lat = 0;

    chs_power_ramp #(
        .CONF_W   (CONF_W),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .chs_conf_valid (chs_conf_valid),
        .chs_conf       (chs_conf),
        .chs_conf_ready (chs_conf_ready),
        .chs_power      (chs_power),
        .chs_mode       (chs_mode),
        .chs_busy       (chs_busy),
        .chs_done       (chs_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs e edges after acceptance, from the ramp rules.
    function automatic void model(input txn_t x, input int unsigned e,
                                  output int unsigned pw, output bit md,
                                  output bit bz, output bit dn);
        int unsigned n;
        int unsigned d;
        int unsigned s;
        n  = e / RAMP_DIV;
        pw = x.p0;
        md = x.m0;
`ifdef CHS_SOFT_START_EN
        if ((x.m0 != x.tm) && (x.p0 != 0)) begin
            if (n < x.p0) begin
                pw = x.p0 - n;
                md = x.m0;
            end else begin
                pw = ((n - x.p0) < x.t) ? (n - x.p0) : x.t;
                md = x.tm;
            end
        end else begin
            d  = (x.t > x.p0) ? (x.t - x.p0) : (x.p0 - x.t);
            s  = (n < d) ? n : d;
            pw = (x.t > x.p0) ? (x.p0 + s) : (x.p0 - s);
            md = x.tm;
        end
`else
        if (e >= 1) begin
            pw = x.t;
            md = x.tm;
        end
`endif
        bz = x.moves && (e < x.lat);
        dn = (e == x.lat);
    endfunction

    // Present a word at the current negedge and queue its expected response.
    task automatic issue_start(input logic [CONF_W-1:0] w);
        txn_t        x;
        int unsigned guard;
        guard = 0;
        while (!chs_conf_ready && guard < 200) begin
            chs_conf_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        chk("ready_before_issue", 32'(chs_conf_ready), 1);
        x.acc = cyc + 1;
        x.p0  = cur_p;
        x.m0  = cur_m;
        x.t   = $countones(w);
        x.tm  = x.t[0];
`ifdef CHS_SOFT_START_EN
        if ((x.m0 != x.tm) && (x.p0 != 0)) begin
            x.lat   = RAMP_DIV * (x.p0 + x.t);
            x.moves = 1'b1;
        end else if (x.t == x.p0) begin
            x.lat   = 1;
            x.moves = 1'b0;
        end else begin
            x.lat   = RAMP_DIV * ((x.t > x.p0) ? (x.t - x.p0) : (x.p0 - x.t));
            x.moves = 1'b1;
        end
`else
        x.lat   = 1;
        x.moves = 1'b0;
`endif
        sb.push_back(x);
        cur_p          = x.t;
        cur_m          = x.tm;
        pend_lat       = x.lat;
        chs_conf       = w;
        chs_conf_valid = 1'b1;
    endtask

    // Run until the done edge, offering junk words only while not ready.
    task automatic wait_done();
        for (int k = 0; k <= int'(pend_lat); k++) begin
            @(negedge clk);
            chs_conf_valid = !chs_conf_ready && ($urandom_range(0, 3) != 0);
            chs_conf       = CONF_W'($urandom);
        end
    endtask

    task automatic issue(input logic [CONF_W-1:0] w);
        issue_start(w);
        wait_done();
    endtask

    // Monitor: per-cycle comparison against the head of the scoreboard
    always @(negedge clk) begin
        int unsigned ep;
        bit          em, eb, ed;
        if (rst) begin
            sb.delete();
            last_p = 0;
            last_m = 1'b0;
        end else begin
            if (sb.size() > 0 && cyc >= sb[0].acc) begin
                model(sb[0], cyc - sb[0].acc, ep, em, eb, ed);
            end else begin
                ep = last_p;
                em = last_m;
                eb = 1'b0;
                ed = 1'b0;
            end
            chk("power", 32'(chs_power), ep);
            chk("mode", 32'(chs_mode), 32'(em));
            chk("busy", 32'(chs_busy), 32'(eb));
            chk("ready", 32'(chs_conf_ready), 32'(!eb));
            chk("done", 32'(chs_done), 32'(ed));
            chk("power_range", 32'(chs_power <= PWR_W'(CONF_W)), 1);
            if (ed) begin
                last_p = sb[0].t;
                last_m = sb[0].tm;
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [CONF_W-1:0] w;
        logic [CONF_W-1:0] prev_w;
        int unsigned       target;
        bit                found;

        rst            = 1'b1;
        chs_conf_valid = 1'b0;
        chs_conf       = '0;

        // Outputs held at reset values while reset is asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_power", 32'(chs_power), 0);
            chk("rst_mode", 32'(chs_mode), 0);
            chk("rst_ready", 32'(chs_conf_ready), 1);
            chk("rst_done", 32'(chs_done), 0);
            chk("rst_busy", 32'(chs_busy), 0);
        end
        rst = 1'b0;

        // Directed: heat ramp, drain + mode flip, cool ramp-down, re-accept, drain to zero
        issue(8'h07);
        issue(8'h0F);
        issue(8'h03);
        issue(8'h03);
        issue(8'h00);
        issue(8'h01);
        issue(8'h07);
        issue(8'h00);
        issue(8'hFF);

        // Randomised sequence with corner words mixed in
        prev_w = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chs_conf_valid = 1'b0;
                chs_conf       = CONF_W'($urandom);
            end
            case ($urandom_range(0, 9))
                0:       w = 8'h00;
                1:       w = 8'hFF;
                2:       w = prev_w;
                default: w = CONF_W'($urandom);
            endcase
            prev_w = w;
            issue(w);
        end

        // Asynchronous reset while the applied power is mid-way to target
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        cur_p = 0;
        cur_m = 1'b0;
        issue_start(8'h07);
`ifdef CHS_SOFT_START_EN
        target = 2;
`else
        target = 3;
`endif
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            chs_conf_valid = 1'b0;
            if (int'(chs_power) == int'(target)) found = 1'b1;
        end
        chk("reach_mid_ramp", 32'(found), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_power", 32'(chs_power), 0);
        chk("async_rst_mode", 32'(chs_mode), 0);
        chk("async_rst_busy", 32'(chs_busy), 0);
        chk("async_rst_done", 32'(chs_done), 0);
        chk("async_rst_ready", 32'(chs_conf_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        cur_p = 0;
        cur_m = 1'b0;
        issue(8'h07);
        issue(8'h07);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
